// File: rtl/rc4_prga_engine_if.sv
// Control handshake plus S-RAM, ciphertext-ROM and plaintext-RAM ports of the RC4 PRGA engine.
// The engine takes the slave view; the sequencer and memories take the master view.
interface rc4_prga_engine_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic [MSG_AW:0]   msg_len;
  logic              check_en;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MSG_AW-1:0] fail_idx;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] c_addr;
  logic [7:0]        c_rdata;
  logic [MSG_AW-1:0] p_addr;
  logic [7:0]        p_wdata;
  logic              p_wren;

  modport slave (
    input  start, msg_len, check_en, s_rdata, c_rdata,
    output busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
           c_addr, p_addr, p_wdata, p_wren
  );

  modport master (
    output start, msg_len, check_en, s_rdata, c_rdata,
    input  busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
           c_addr, p_addr, p_wdata, p_wren
  );
endinterface

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA engine: walks the pre-scheduled S RAM, XORs keystream into ciphertext bytes,
// writes plaintext, and optionally aborts on the first byte outside the legal character range.
module rc4_prga_engine #(
  parameter int         MSG_AW  = 5,
  parameter logic [7:0] CHAR_LO = 8'h61,
  parameter logic [7:0] CHAR_HI = 8'h7A
) (
  input  logic             clk,
  input  logic             reset,
  rc4_prga_engine_if.slave bus
);

  localparam int            LW      = MSG_AW + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {MSG_AW{1'b0}}};
  localparam logic [LW-1:0] ONE_K   = LW'(1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_I_RD,
    ST_I_WAIT,
    ST_J_RD,
    ST_J_WAIT,
    ST_SWAP_I,
    ST_SWAP_J,
    ST_X_RD,
    ST_X_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        i, j, si, sj;
  logic [LW-1:0]     k, len;
  logic              chk;
  logic              pass_q;
  logic [MSG_AW-1:0] fail_idx_q;

  logic [7:0]        plain;
  logic              illegal;
  logic [LW-1:0]     k_inc;
  logic [LW-1:0]     len_clamp;

  always_comb begin
    plain     = bus.s_rdata ^ bus.c_rdata;
    illegal   = chk && !((plain == 8'h20) || ((plain >= CHAR_LO) && (plain <= CHAR_HI)));
    k_inc     = k + ONE_K;
    len_clamp = (bus.msg_len > MAX_LEN) ? MAX_LEN : bus.msg_len;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Wait states keep the read address stable so the registered RAM output stays valid.
  always_comb begin
    state_nxt   = state;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wren  = 1'b0;
    bus.p_addr  = '0;
    bus.p_wdata = '0;
    bus.p_wren  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = (bus.msg_len == '0) ? ST_DONE : ST_I_RD;
      end
      ST_I_RD: begin
        bus.s_addr = i + 8'd1;
        state_nxt  = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        bus.s_addr = i;
        state_nxt  = ST_J_RD;
      end
      ST_J_RD: begin
        bus.s_addr = j + bus.s_rdata;
        state_nxt  = ST_J_WAIT;
      end
      ST_J_WAIT: begin
        bus.s_addr = j;
        state_nxt  = ST_SWAP_I;
      end
      ST_SWAP_I: begin
        bus.s_addr  = i;
        bus.s_wdata = bus.s_rdata;
        bus.s_wren  = 1'b1;
        state_nxt   = ST_SWAP_J;
      end
      ST_SWAP_J: begin
        bus.s_addr  = j;
        bus.s_wdata = si;
        bus.s_wren  = 1'b1;
        state_nxt   = ST_X_RD;
      end
      ST_X_RD: begin
        bus.s_addr = si + sj;
        state_nxt  = ST_X_WAIT;
      end
      ST_X_WAIT: begin
        bus.s_addr = si + sj;
        state_nxt  = ST_OUT;
      end
      ST_OUT: begin
        if (illegal) begin
          state_nxt = ST_DONE;
        end else begin
          bus.p_addr  = k[MSG_AW-1:0];
          bus.p_wdata = plain;
          bus.p_wren  = 1'b1;
          state_nxt   = (k_inc == len) ? ST_DONE : ST_I_RD;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i          <= '0;
      j          <= '0;
      si         <= '0;
      sj         <= '0;
      k          <= '0;
      len        <= '0;
      chk        <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            len        <= len_clamp;
            chk        <= bus.check_en;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            pass_q     <= (bus.msg_len == '0);
            fail_idx_q <= '0;
          end
        end
        ST_I_RD: i <= i + 8'd1;
        ST_J_RD: begin
          si <= bus.s_rdata;
          j  <= j + bus.s_rdata;
        end
        ST_SWAP_I: sj <= bus.s_rdata;
        ST_OUT: begin
          if (illegal) begin
            pass_q     <= 1'b0;
            fail_idx_q <= k[MSG_AW-1:0];
          end else begin
            k <= k_inc;
            if (k_inc == len) pass_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done     = (state == ST_DONE);
  assign bus.pass     = pass_q;
  assign bus.fail_idx = fail_idx_q;
  assign bus.c_addr   = k[MSG_AW-1:0];

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Scoreboard bench for rc4_prga_engine: stimulus pushes expected writes and done results,
// a negedge monitor pops and compares whenever the engine writes plaintext or pulses done.
module tb_rc4_prga_engine;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_prga_engine_if #(.MSG_AW(AW)) bus ();

  rc4_prga_engine #(.MSG_AW(AW), .CHAR_LO(8'h61), .CHAR_HI(8'h7A)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int acc; int due; int pass; int fidx; int n_wr; int n_sw;} done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rst_q    = 1'b0;
  logic load_s   = 1'b0;
  logic run_open = 1'b0;

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] key_s  [256];
  logic [7:0] c_mem  [32];
  int         m_s    [256];

  logic [7:0] pt_key [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_key [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // S RAM and ciphertext ROM with registered 1-cycle read data
  always @(posedge clk) begin
    if (load_s) s_mem <= s_init;
    else if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
    bus.s_rdata <= s_mem[bus.s_addr];
    bus.c_rdata <= c_mem[bus.c_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    wr_t   w;
    done_t e;
    int    wr_cnt;
    int    sw_cnt;
    logic  prev_done;
    wr_cnt = 0;
    sw_cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_ctrl", int'({bus.busy, bus.done, bus.pass, bus.fail_idx, bus.s_wren, bus.p_wren}), 0);
        chk("rst_s_bus", int'({bus.s_addr, bus.s_wdata}), 0);
        chk("rst_cp_bus", int'({bus.c_addr, bus.p_addr, bus.p_wdata}), 0);
        chk("rst_pending_wr", exp_wr.size(), 0);
        exp_wr.delete();
        wr_cnt = 0;
        sw_cnt = 0;
        prev_done = 1'b0;
      end else begin
        if (bus.s_wren) begin
          sw_cnt++;
          chk("s_wren_in_run", int'(run_open), 1);
          chk("wren_exclusive", int'(bus.p_wren), 0);
        end
        if (bus.p_wren) begin
          wr_cnt++;
          chk("p_wren_expected", int'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("p_addr", int'(bus.p_addr), w.addr);
            chk("p_wdata", int'(bus.p_wdata), w.data);
          end
        end
        if (exp_done.size() > 0 && cyc == exp_done[0].acc && exp_done[0].due > exp_done[0].acc)
          chk("busy_first", int'(bus.busy), 1);
        if (bus.done) begin
          chk("done_expected", int'(exp_done.size() > 0), 1);
          if (exp_done.size() > 0) begin
            e = exp_done.pop_front();
            chk("done_cycle", cyc - e.acc, e.due - e.acc);
            chk("pass", int'(bus.pass), e.pass);
            chk("fail_idx", int'(bus.fail_idx), e.fidx);
            chk("p_write_count", wr_cnt, e.n_wr);
            chk("s_write_count", sw_cnt, e.n_sw);
            chk("busy_at_done", int'(bus.busy), 0);
            chk("done_width", int'(prev_done), 0);
          end
          wr_cnt = 0;
          sw_cnt = 0;
        end else if (exp_done.size() > 0 && cyc > exp_done[0].due) begin
          chk("done_late", int'(bus.done), 1);
          void'(exp_done.pop_front());
          wr_cnt = 0;
          sw_cnt = 0;
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] t;
    int jj;
    key[0] = 8'h4B;
    key[1] = 8'h65;
    key[2] = 8'h79;
    jj = 0;
    for (int n = 0; n < 256; n++) key_s[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      jj = (jj + int'(key_s[n]) + int'(key[n % 3])) % 256;
      t = key_s[n];
      key_s[n] = key_s[jj];
      key_s[jj] = t;
    end
  endtask

  task automatic load_mem(input bit use_key);
    for (int n = 0; n < 256; n++) begin
      s_init[n] = use_key ? key_s[n] : 8'(n);
      m_s[n]    = int'(s_init[n]);
    end
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  // Software RC4 keystream over the bench's own copy of S
  task automatic model_prga(input int len);
    int mi, mj, t, ks;
    mi = 0;
    mj = 0;
    for (int n = 0; n < len; n++) begin
      mi = (mi + 1) % 256;
      mj = (mj + m_s[mi]) % 256;
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      ks = m_s[(m_s[mi] + m_s[mj]) % 256];
      exp_wr.push_back('{n, ks ^ int'(c_mem[n])});
    end
  endtask

  task automatic launch(input int len, input bit ce, input bit push, input int ep, input int efi,
                        input int nwr, input int nsw, input int due_off, output int acc);
    bus.msg_len  = len[AW:0];
    bus.check_en = ce;
    bus.start    = 1'b1;
    run_open     = 1'b1;
    acc          = cyc + 1;
    if (push) exp_done.push_back('{acc, acc + due_off, ep, efi, nwr, nsw});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_done.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        $display("FAIL watchdog: done never resolved after %0d cycles", n);
        $fatal(1, "watchdog");
      end
    end
    run_open = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_key_cipher();
    for (int n = 0; n < 32; n++) c_mem[n] = (n < 9) ? ct_key[n] : 8'h00;
  endtask

  initial begin : stimulus
    int acc;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.msg_len  = '0;
    bus.check_en = 1'b0;
    for (int n = 0; n < 32; n++) c_mem[n] = 8'h00;
    ksa_key();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Known vector, key "Key", with start pulses while busy and in DONE
    load_mem(1'b1);
    load_key_cipher();
    for (int n = 0; n < 9; n++) exp_wr.push_back('{n, int'(pt_key[n])});
    launch(9, 1'b0, 1'b1, 1, 0, 9, 18, 81, acc);
    while (cyc < acc + 82) begin
      @(negedge clk);
      bus.start = (cyc == acc + 3) || (cyc == acc + 40) || (cyc == acc + 81);
    end
    bus.start = 1'b0;
    wait_done();

    // Range check: 'P' is below CHAR_LO, abort at byte 0
    load_mem(1'b1);
    launch(9, 1'b1, 1'b1, 0, 0, 0, 2, 9, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Plaintext "ab D..." : space is legal, 'D' aborts at byte 3
    load_mem(1'b1);
    c_mem[0] = 8'h8A; c_mem[1] = 8'hFD; c_mem[2] = 8'h57; c_mem[3] = 8'hC5;
    exp_wr.push_back('{0, 'h61});
    exp_wr.push_back('{1, 'h62});
    exp_wr.push_back('{2, 'h20});
    launch(9, 1'b1, 1'b1, 0, 3, 3, 8, 36, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Plaintext "az{" : CHAR_HI itself legal, one above aborts at byte 2
    load_mem(1'b1);
    c_mem[0] = 8'h8A; c_mem[1] = 8'hE5; c_mem[2] = 8'h0C;
    exp_wr.push_back('{0, 'h61});
    exp_wr.push_back('{1, 'h7A});
    launch(9, 1'b1, 1'b1, 0, 2, 2, 6, 27, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Zero length
    launch(0, 1'b1, 1'b1, 1, 0, 0, 0, 0, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset during byte 3 (J_RD): no done, no writes afterwards
    load_mem(1'b1);
    load_key_cipher();
    for (int n = 0; n < 3; n++) exp_wr.push_back('{n, int'(pt_key[n])});
    launch(9, 1'b0, 1'b0, 0, 0, 0, 0, 0, acc);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < acc + 29) @(negedge clk);
    reset    = 1'b1;
    run_open = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Identity S, full 32-byte message
    load_mem(1'b0);
    for (int n = 0; n < 32; n++) c_mem[n] = 8'(n * 37 + 5);
    model_prga(32);
    launch(32, 1'b0, 1'b1, 1, 0, 32, 64, 288, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Oversize length clamps to 32
    load_mem(1'b0);
    model_prga(32);
    launch(50, 1'b0, 1'b1, 1, 0, 32, 64, 288, acc);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Back-to-back: start held high, second run continues on the modified S
    load_mem(1'b0);
    model_prga(3);
    model_prga(3);
    launch(3, 1'b0, 1'b1, 1, 0, 3, 6, 27, acc);
    exp_done.push_back('{acc + 29, acc + 56, 1, 0, 3, 6});
    while (cyc < acc + 29) @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
